// File: rtl/euler_pkg.sv
// Shared types and helpers for the multi-channel Euler integrator.
package euler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } euler_state_e;

  // Result of a saturating add: clamped sum plus a flag set when clamping occurred.
  typedef struct packed {
    logic [63:0] sum;
    logic        clamped;
  } sat_res_t;

  // Largest value representable in a w-bit signed word (w <= 63).
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit signed word (w <= 63).
  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Operands are sign-extended w-bit words, so the exact sum needs only w+1 bits
  // and the 64-bit add can never wrap.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned        w);
    logic signed [63:0] s;
    sat_res_t           res;
    s = a + b;
    if (s > sat_max(w)) begin
      res.sum     = sat_max(w);
      res.clamped = 1'b1;
    end else if (s < sat_min(w)) begin
      res.sum     = sat_min(w);
      res.clamped = 1'b1;
    end else begin
      res.sum     = s;
      res.clamped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/euler_integrator_mc_if.sv
// Control/data bundle between the integrator and its environment.
interface euler_integrator_mc_if #(
  parameter int unsigned W     = 27,
  parameter int unsigned N     = 3,
  parameter int unsigned CNT_W = 32
) ();
  logic             start;
  logic             init_load;
  logic [N*W-1:0]   init_state;
  logic [N*W-1:0]   funct;
  logic             busy;
  logic             done;
  logic [N*W-1:0]   state;
  logic [CNT_W-1:0] step_count;
  logic [N-1:0]     ovf;

  modport master (
    output start, init_load, init_state, funct,
    input  busy, done, state, step_count, ovf
  );

  modport slave (
    input  start, init_load, init_state, funct,
    output busy, done, state, step_count, ovf
  );
endinterface

// File: rtl/euler_sat_adder.sv
// Shared datapath: acc + (deriv >>> DT_SHIFT), clamped to the W-bit signed range.
module euler_sat_adder
  import euler_pkg::*;
#(
  parameter int unsigned W        = 27,
  parameter int unsigned DT_SHIFT = 8
) (
  input  logic signed [W-1:0] i_acc,
  input  logic signed [W-1:0] i_deriv,
  output logic signed [W-1:0] o_sum,
  output logic                o_clamped
);

  logic signed [W-1:0] w_shifted;
  sat_res_t            w_res;
  logic                w_unused_hi;

  // Arithmetic shift floors toward minus infinity, so -1 stays -1.
  assign w_shifted = i_deriv >>> DT_SHIFT;

  // Sign-extend both operands, add and clamp.
  always_comb begin
    w_res     = sat_add({{(64 - W){i_acc[W-1]}}, i_acc},
                        {{(64 - W){w_shifted[W-1]}}, w_shifted}, W);
    o_sum     = w_res.sum[W-1:0];
    o_clamped = w_res.clamped;
  end

  // After clamping the upper bits are pure sign extension.
  assign w_unused_hi = ^w_res.sum[63:W];

endmodule

// File: rtl/euler_integrator_mc.sv
// Multi-channel Euler integrator: one shared saturating adder walks the channels,
// and the published state vector only changes in the DONE cycle.
module euler_integrator_mc
  import euler_pkg::*;
#(
  parameter int unsigned W        = 27,
  parameter int unsigned N        = 3,
  parameter int unsigned DT_SHIFT = 8,
  parameter int unsigned CNT_W    = 32
) (
  input logic                  clk,
  input logic                  reset,
  euler_integrator_mc_if.slave bus
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  euler_state_e        r_fsm, w_fsm_next;
  logic [IdxW-1:0]     r_idx;
  logic signed [W-1:0] r_work [N];
  logic signed [W-1:0] r_snap [N];
  logic [N*W-1:0]      r_pub;
  logic [CNT_W-1:0]    r_cnt;
  logic [N-1:0]        r_ovf;
  logic                r_busy, r_done;

  logic                w_load, w_accept, w_step, w_publish, w_last;
  logic signed [W-1:0] w_add_acc, w_add_der, w_add_sum;
  logic                w_add_clamp;
  logic [N*W-1:0]      w_work_flat;

  // Next-state and datapath strobes.
  always_comb begin
    w_fsm_next = r_fsm;
    w_load     = 1'b0;
    w_accept   = 1'b0;
    w_step     = 1'b0;
    w_publish  = 1'b0;
    w_last     = (r_idx == IdxW'(N - 1));
    unique case (r_fsm)
      StIdle: begin
        // init_load takes priority; a simultaneous start is dropped.
        if (bus.init_load) begin
          w_load = 1'b1;
        end else if (bus.start) begin
          w_accept   = 1'b1;
          w_fsm_next = StRun;
        end
      end
      StRun: begin
        w_step = 1'b1;
        if (w_last) w_fsm_next = StDone;
      end
      StDone: begin
        w_publish  = 1'b1;
        w_fsm_next = StIdle;
      end
      default: w_fsm_next = StIdle;
    endcase
  end

  // FSM state plus registered busy/done flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fsm  <= StIdle;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_next;
      r_busy <= (w_fsm_next != StIdle);
      r_done <= w_publish;
    end
  end

  // Select the channel currently being integrated.
  always_comb begin
    w_add_acc = r_work[0];
    w_add_der = r_snap[0];
    for (int i = 0; i < N; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_add_acc = r_work[i];
        w_add_der = r_snap[i];
      end
    end
  end

  euler_sat_adder #(
    .W        (W),
    .DT_SHIFT (DT_SHIFT)
  ) u_sat_adder (
    .i_acc     (w_add_acc),
    .i_deriv   (w_add_der),
    .o_sum     (w_add_sum),
    .o_clamped (w_add_clamp)
  );

  // Flatten the working array for the atomic publish.
  always_comb begin
    w_work_flat = '0;
    for (int i = 0; i < N; i++) begin
      w_work_flat[i*W +: W] = r_work[i];
    end
  end

  // Working/published state, derivative snapshot, channel index, counter and ovf.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        r_work[i] <= bus.init_state[i*W +: W];
        r_snap[i] <= '0;
      end
      r_pub <= bus.init_state;
      r_cnt <= '0;
      r_ovf <= '0;
      r_idx <= '0;
    end else begin
      if (w_load) begin
        for (int i = 0; i < N; i++) begin
          r_work[i] <= bus.init_state[i*W +: W];
        end
        r_pub <= bus.init_state;
        r_ovf <= '0;
      end
      if (w_accept) begin
        for (int i = 0; i < N; i++) begin
          r_snap[i] <= bus.funct[i*W +: W];
        end
        r_idx <= '0;
      end
      if (w_step) begin
        for (int i = 0; i < N; i++) begin
          if (r_idx == IdxW'(i)) begin
            r_work[i] <= w_add_sum;
            if (w_add_clamp) r_ovf[i] <= 1'b1;
          end
        end
        r_idx <= r_idx + 1'b1;
      end
      if (w_publish) begin
        r_pub <= w_work_flat;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.state      = r_pub;
  assign bus.step_count = r_cnt;
  assign bus.ovf        = r_ovf;

endmodule
